adder_share_arbiter: RTL

- Shares one 16-bit carry-lookahead adder between NUM_REQ requesters, each on a valid/ready request channel.
- A round-robin arbiter grants one request per cycle. The adder result is written, tagged with the requester index, into a small response FIFO drained over one valid/ready response channel.
- Sits between ToyALU issue logic and the adder datapath. It is the only instantiator of the adder in the ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/adder_rsp_fifo.sv | 72 +++++++
 rtl/cla_adder16.sv | 46 ++++
 rtl/adder_share_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: response entry layout and the round-robin picker.
// Widths are sized for the largest supported requester count (8).
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DATA_W-1:0]   sum;
        logic                overflow;
    } rsp_entry_t;

    // One-hot grant: first valid index at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_REQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && g == '0 && valid[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_rsp_fifo.sv
// Synchronous FIFO of response entries with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module adder_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  rsp_entry_t               wdata,
    input  logic                     pop,
    output rsp_entry_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    rsp_entry_t  mem_q [DEPTH];
    rsp_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder (4-bit groups).
// Group generate/propagate feed a lookahead across the four groups.
module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic [16:0] c;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gg = '0;
        gp = '1;
        c  = '0;
        for (int grp = 0; grp < 4; grp++) begin
            for (int j = 0; j < 4; j++) begin
                gg[grp] = g[4*grp+j] | (p[4*grp+j] & gg[grp]);
                gp[grp] = gp[grp] & p[4*grp+j];
            end
        end
        gc[0] = cin;
        for (int grp = 0; grp < 4; grp++) begin
            gc[grp+1] = gg[grp] | (gp[grp] & gc[grp]);
        end
        for (int grp = 0; grp < 4; grp++) begin
            c[4*grp] = gc[grp];
            for (int j = 1; j < 4; j++) begin
                c[4*grp+j] = g[4*grp+j-1]
                           | (p[4*grp+j-1] & c[4*grp+j-1]);
            end
        end
        c[16] = gc[4];
        sum   = p ^ c[15:0];
        cout  = c[16];
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 16-bit CLA adder between NUM_REQ requesters.
// Results are tagged with the requester index and queued for one consumer.
module adder_share_arbiter
    import alu_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  RSP_DEPTH = 2,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_overflow,
    output logic                      busy
);

    logic [MAX_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    rsp_entry_t          last_q, last_d;
    logic [MAX_REQ-1:0]  valid_ext;
    logic [MAX_REQ-1:0]  grant_ext;
    logic [NUM_REQ-1:0]  grant;
    logic [MAX_ID_W-1:0] gid;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [DATA_W-1:0]   add_sum;
    logic                add_cout;
    logic                can_push;
    logic                accept;
    logic                pop;
    rsp_entry_t          wr_entry;
    rsp_entry_t          head;
    rsp_entry_t          shown;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(RSP_DEPTH):0] fifo_count;
    logic                unused_bits;

    assign valid_ext = MAX_REQ'(req_valid);
    assign grant_ext = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);
    assign grant     = grant_ext[NUM_REQ-1:0];

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        gid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*DATA_W +: DATA_W];
                b_sel = req_b[i*DATA_W +: DATA_W];
                gid   = MAX_ID_W'(i);
            end
        end
    end

    cla_adder16 u_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;
    assign can_push  = ~fifo_full | pop;
    // Held low through reset so nothing is accepted before release.
    assign req_ready = rst_n ? (grant & {NUM_REQ{can_push}}) : '0;
    assign accept    = |(req_valid & req_ready);

    assign wr_entry = '{id: gid, sum: add_sum, overflow: add_cout};

    adder_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gid == MAX_ID_W'(NUM_REQ-1))
                     ? '0 : gid + MAX_ID_W'(1);
        end
        last_d = pop ? head : last_q;
    end

    // Once drained, the outputs keep showing the last entry handed out.
    assign shown        = fifo_empty ? last_q : head;
    assign rsp_id       = shown.id[ID_W-1:0];
    assign rsp_sum      = shown.sum;
    assign rsp_overflow = shown.overflow;
    assign busy         = ~fifo_empty | (|req_valid);

    assign unused_bits = ^{shown.id, grant_ext, fifo_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            last_q   <= last_d;
        end
    end

endmodule
